if_id_fetch_stage: RTL and testbench
====================================

// Module: if_id_fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
//  Holds the PC and fetches 32-bit words from instruction memory over a req/gnt + rvalid handshake.
//  Presents the fetched instruction, PC+4 and the raw 16-bit immediate to the ID stage.
//  ID consumes if_id_imm_o in the 16->32 sign-extension unit; stall, flush and redirect come from the hazard/branch logic.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0000  word driven on if_id_instr_o for a bubble (sll $0,$0,0)
// PORTS
//  clk            in   1   single clock, rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  stall_i        in   1   hazard unit: freeze PC and IF/ID contents
//  flush_i        in   1   branch/jump resolved: squash the IF/ID contents
//  redirect_i     in   1   load redirect_pc_i as next fetch PC
//  redirect_pc_i  in   32  branch/jump target, word aligned
//  imem_req_o     out  1   fetch request
//  imem_addr_o    out  32  fetch address (current PC)
//  imem_gnt_i     in   1   memory accepted request this cycle
//  imem_rvalid_i  in   1   read data valid
//  imem_rdata_i   in   32  instruction word
//  if_id_valid_o  out  1   IF/ID holds a real instruction
//  if_id_instr_o  out  32  instruction (NOP_INSTR when invalid)
//  if_id_pc4_o    out  32  PC+4 of that instruction
//  if_id_imm_o    out  16  if_id_instr_o[15:0], to the sign-extension unit
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, state=IDLE, imem_req_o=0, imem_addr_o=RESET_PC,
//   if_id_valid_o=0, if_id_instr_o=NOP_INSTR, if_id_pc4_o=0, if_id_imm_o=0, kill=0.
//  FSM: IDLE -> REQ (1 cycle after reset release); REQ: imem_req_o=1, addr=pc; gnt -> WAIT.
//   WAIT: on rvalid with kill=0 and stall_i=0 -> load IF/ID (valid=1), pc<=pc+4, -> REQ.
//   WAIT: on rvalid with stall_i=1 -> capture word in holding reg, -> HOLD.
//   HOLD: on stall_i=0 -> load IF/ID from holding reg, pc<=pc+4, -> REQ.
//  At most one outstanding request; imem_addr_o stable while imem_req_o=1 and gnt=0.
//  Latency: gnt in cycle N, rvalid in N+k -> IF/ID valid from cycle N+k+1. Back-to-back best case:
//   one instruction per 2 cycles (no request issued in the rvalid cycle).
//  stall_i: IF/ID outputs and pc unchanged; an in-flight response is still accepted into HOLD.
//  flush_i: IF/ID valid<=0, instr<=NOP_INSTR next edge; flush beats stall when both high.
//  redirect_i: pc<=redirect_pc_i next edge, holding reg dropped. In REQ: request re-targets next cycle.
//   In WAIT: kill<=1, pending rvalid discarded (kill cleared), then -> REQ at new pc. In HOLD: -> REQ.
//   redirect_i and rvalid same cycle: response discarded, redirect pc used.
//   Redirect is typically accompanied by flush_i; redirect alone does not clear IF/ID.
//  PC arithmetic: 32-bit, pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently; pc[1:0] forced 0.
//  if_id_pc4_o = fetch pc + 4 (same wrap).
// CONFIGURATION
//  IFETCH_PERF_EN defined: adds outputs perf_fetch_cnt_o[31:0] (IF/ID loads with valid=1)
//   and perf_bubble_cnt_o[31:0] (cycles with if_id_valid_o=0 and stall_i=0), reset to 0, wrap at 2^32.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package cpu_pkg: fetch_state_t enum (IDLE, REQ, WAIT, HOLD), NOP_WORD, WORD_W=32, IMM_W=16.
//  One sub-module: if_id_latch (IF/ID register with load/flush/stall priority); FSM+PC in top.
// TESTING
//  Reset release, gnt=1, rvalid 1 cycle later, rdata=32'h2008_FFFF -> if_id_valid_o=1,
//   instr=32'h2008_FFFF, imm=16'hFFFF, pc4=32'h4, next imem_addr_o=32'h4.
//  stall_i=1 for 3 cycles while rvalid arrives with 32'h8C01_0010 -> IF/ID unchanged during stall;
//   word appears in IF/ID the cycle after stall_i drops, no new request until then.
//  redirect_i=1, redirect_pc_i=32'h0000_0100 in WAIT, then rvalid -> response discarded,
//   next imem_addr_o=32'h100, IF/ID never shows discarded word.
//  flush_i=1 and stall_i=1 same cycle with valid IF/ID -> next cycle if_id_valid_o=0, instr=NOP_INSTR.
//  RESET_PC=32'hFFFF_FFFC, fetch one word -> pc4=32'h0, next imem_addr_o=32'h0.
//  reset_n asserted mid-WAIT -> all outputs at reset values immediately (async); late rvalid after
//   release ignored, first request at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//   fetch_state_t : fetch FSM encoding (IDLE, REQ, WAIT, HOLD)
//   WORD_W/IMM_W  : instruction word and raw immediate widths
//   NOP_WORD      : sll $0,$0,0 used for bubbles
//   pc_inc()      : word-aligned PC+4 with silent 32-bit wrap
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam int IMM_W  = 16;

  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // Low bits are cleared so a misaligned value can never leak into the PC.
  function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
    return (pc + 32'd4) & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register.
//   clk, reset_n      : clock, async active-low reset
//   flush, stall, load: update controls, priority flush > stall > load
//   instr_in, pc4_in  : word and PC+4 to capture on load
//   valid, instr, pc4 : registered IF/ID contents
// Without load, stall or flush the contents are simply held.
module if_id_latch
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              load,
  input  logic [WORD_W-1:0] instr_in,
  input  logic [WORD_W-1:0] pc4_in,
  output logic              valid,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc4
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc4   <= '0;
    end else if (flush) begin
      // pc4 is left alone; it is meaningless while valid is low.
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (stall) begin
      valid <= valid;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc4   <= pc4_in;
    end
  end

endmodule

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage + IF/ID register of the 5-stage MIPS pipeline.
//   clk, reset_n                 : clock, async active-low reset
//   stall_i, flush_i             : hazard unit freeze / squash IF/ID
//   redirect_i, redirect_pc_i    : load a new fetch PC next edge
//   imem_req_o, imem_addr_o      : fetch request and address (current PC)
//   imem_gnt_i, imem_rvalid_i,
//   imem_rdata_i                 : memory accept / response handshake
//   if_id_valid_o, if_id_instr_o,
//   if_id_pc4_o, if_id_imm_o     : IF/ID contents to the ID stage
// Optional macro IFETCH_PERF_EN adds perf_fetch_cnt_o and perf_bubble_cnt_o.
// One request is outstanding at most. A redirect that overtakes an in-flight
// request sets kill so the stale response is dropped when it returns.
module if_id_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [WORD_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [WORD_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [WORD_W-1:0] imem_rdata_i,
`ifdef IFETCH_PERF_EN
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_bubble_cnt_o,
`endif
  output logic              if_id_valid_o,
  output logic [WORD_W-1:0] if_id_instr_o,
  output logic [WORD_W-1:0] if_id_pc4_o,
  output logic [IMM_W-1:0]  if_id_imm_o
);

  fetch_state_t      state, state_nxt;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] hold_q;
  logic              kill;

  logic load_new, load_hold, capture, advance, kill_set, kill_clr;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ:  if (imem_gnt_i) state_nxt = WAIT;
      WAIT: if (imem_rvalid_i) begin
              if (kill || redirect_i) state_nxt = REQ;
              else if (stall_i)       state_nxt = HOLD;
              else                    state_nxt = REQ;
            end
      HOLD: if (redirect_i || !stall_i) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    imem_req_o = 1'b0;
    load_new   = 1'b0;
    load_hold  = 1'b0;
    capture    = 1'b0;
    kill_set   = 1'b0;
    kill_clr   = 1'b0;
    case (state)
      REQ: begin
        imem_req_o = 1'b1;
        // Granted for the old PC while retargeting: its data is stale.
        kill_set   = imem_gnt_i && redirect_i;
      end
      WAIT: begin
        load_new = imem_rvalid_i && !kill && !redirect_i && !stall_i;
        capture  = imem_rvalid_i && !kill && !redirect_i &&  stall_i;
        kill_set = redirect_i && !imem_rvalid_i;
        kill_clr = imem_rvalid_i;
      end
      HOLD: load_hold = !redirect_i && !stall_i;
      default: ;
    endcase
  end

  assign advance     = load_new || load_hold;
  assign imem_addr_o = pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= RESET_PC;
      kill   <= 1'b0;
      hold_q <= NOP_INSTR;
    end else begin
      if (redirect_i)   pc <= redirect_pc_i & 32'hFFFF_FFFC;
      else if (advance) pc <= pc_inc(pc);

      if (kill_set)      kill <= 1'b1;
      else if (kill_clr) kill <= 1'b0;

      if (redirect_i)   hold_q <= NOP_INSTR;
      else if (capture) hold_q <= imem_rdata_i;
    end
  end

  if_id_latch #(.NOP_INSTR(NOP_INSTR)) u_latch (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush_i),
    .stall    (stall_i),
    .load     (advance),
    .instr_in (load_hold ? hold_q : imem_rdata_i),
    .pc4_in   (pc_inc(pc)),
    .valid    (if_id_valid_o),
    .instr    (if_id_instr_o),
    .pc4      (if_id_pc4_o)
  );

  assign if_id_imm_o = if_id_instr_o[IMM_W-1:0];

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_cnt_o  <= '0;
      perf_bubble_cnt_o <= '0;
    end else begin
      if (advance && !flush_i)            perf_fetch_cnt_o  <= perf_fetch_cnt_o + 32'd1;
      if (!if_id_valid_o && !stall_i)     perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
module tb_if_id_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n, stall, flush, redirect, gnt, rvalid;
  logic [31:0] redirect_pc, rdata;
  logic        req, valid;
  logic [31:0] addr, instr, pc4;
  logic [15:0] imm;

  // Second instance for the wrap-around reset PC.
  logic        b_rst_n, b_gnt, b_rvalid, b_zero;
  logic [31:0] b_rdata, b_zero32;
  logic        b_req, b_valid;
  logic [31:0] b_addr, b_instr, b_pc4;
  logic [15:0] b_imm;

`ifdef IFETCH_PERF_EN
  logic [31:0] pf_a, pb_a, pf_b, pb_b;
`endif

  always #5 clk = ~clk;

  if_id_fetch_stage dut (
    .clk(clk), .reset_n(reset_n), .stall_i(stall), .flush_i(flush),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
`ifdef IFETCH_PERF_EN
    .perf_fetch_cnt_o(pf_a), .perf_bubble_cnt_o(pb_a),
`endif
    .if_id_valid_o(valid), .if_id_instr_o(instr), .if_id_pc4_o(pc4),
    .if_id_imm_o(imm)
  );

  if_id_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .reset_n(b_rst_n), .stall_i(b_zero), .flush_i(b_zero),
    .redirect_i(b_zero), .redirect_pc_i(b_zero32),
    .imem_req_o(b_req), .imem_addr_o(b_addr), .imem_gnt_i(b_gnt),
    .imem_rvalid_i(b_rvalid), .imem_rdata_i(b_rdata),
`ifdef IFETCH_PERF_EN
    .perf_fetch_cnt_o(pf_b), .perf_bubble_cnt_o(pb_b),
`endif
    .if_id_valid_o(b_valid), .if_id_instr_o(b_instr), .if_id_pc4_o(b_pc4),
    .if_id_imm_o(b_imm)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] w, input logic [31:0] p4);
    exp_t e;
    e.instr = w;
    e.pc4   = p4;
    exp_q.push_back(e);
  endtask

  // Monitor: a new IF/ID instruction is a rising valid or a changed pc4.
  logic        prev_v   = 1'b0;
  logic [31:0] prev_pc4 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (valid && (!prev_v || pc4 !== prev_pc4)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ifid_word", instr, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", instr, e.instr);
        chk("sb_pc4", pc4, e.pc4);
        chk("sb_imm", {16'h0, imm}, {16'h0, e.instr[15:0]});
      end
    end
    prev_v   = valid;
    prev_pc4 = pc4;
  end

  initial begin
    reset_n = 0; stall = 0; flush = 0; redirect = 0; redirect_pc = '0;
    gnt = 0; rvalid = 0; rdata = '0;
    b_rst_n = 0; b_gnt = 0; b_rvalid = 0; b_rdata = '0; b_zero = 0; b_zero32 = '0;

    #3;
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc4", pc4, 32'h0);
    chk("rst_imm", {16'h0, imm}, 32'h0);
    step(); step();
    reset_n = 1;

    // Basic fetch
    step();
    chk("req_after_idle", {31'h0, req}, 32'h1);
    chk("first_addr", addr, 32'h0);
    gnt = 1;
    step();
    gnt = 0;
    chk("no_req_in_wait", {31'h0, req}, 32'h0);
    rvalid = 1; rdata = 32'h2008_FFFF; expect_word(32'h2008_FFFF, 32'h4);
    step();
    rvalid = 0;
    chk("f1_valid", {31'h0, valid}, 32'h1);
    chk("f1_imm", {16'h0, imm}, 32'h0000_FFFF);
    chk("f1_next_addr", addr, 32'h4);

    // Stall across the response
    gnt = 1;
    step();
    gnt = 0; stall = 1; rvalid = 1; rdata = 32'h8C01_0010;
    expect_word(32'h8C01_0010, 32'h8);
    step();
    rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_instr", instr, 32'h2008_FFFF);
      chk("stall_pc4", pc4, 32'h4);
      chk("stall_no_req", {31'h0, req}, 32'h0);
      if (i == 2) stall = 0;
      else        step();
    end
    step();
    chk("hold_release_instr", instr, 32'h8C01_0010);
    chk("hold_release_addr", addr, 32'h8);
    chk("hold_release_req", {31'h0, req}, 32'h1);

    // Redirect while waiting, stale response returns afterwards
    gnt = 1;
    step();
    gnt = 0; redirect = 1; redirect_pc = 32'h0000_0100;
    step();
    redirect = 0; rvalid = 1; rdata = 32'hDEAD_BEEF;
    step();
    rvalid = 0;
    chk("redir_addr", addr, 32'h100);
    chk("redir_req", {31'h0, req}, 32'h1);
    chk("redir_keeps_ifid", instr, 32'h8C01_0010);
    gnt = 1;
    step();
    gnt = 0; rvalid = 1; rdata = 32'h0043_2020; expect_word(32'h0043_2020, 32'h104);
    step();
    rvalid = 0;
    chk("f3_valid", {31'h0, valid}, 32'h1);

    // Flush beats stall
    flush = 1; stall = 1;
    step();
    flush = 0; stall = 0;
    chk("flush_valid", {31'h0, valid}, 32'h0);
    chk("flush_instr", instr, 32'h0);

    // Redirect coinciding with rvalid
    gnt = 1;
    step();
    gnt = 0; rvalid = 1; rdata = 32'hBAD0_BAD0; redirect = 1; redirect_pc = 32'h0000_0200;
    step();
    rvalid = 0; redirect = 0;
    chk("redir_rv_addr", addr, 32'h200);
    chk("redir_rv_valid", {31'h0, valid}, 32'h0);

    // Fetch at 0x200, then reset in the middle of the next WAIT
    gnt = 1;
    step();
    gnt = 0; rvalid = 1; rdata = 32'h2402_0005; expect_word(32'h2402_0005, 32'h204);
    step();
    rvalid = 0; gnt = 1;
    step();
    gnt = 0;
    #2 reset_n = 0;
    #1;
    chk("arst_req", {31'h0, req}, 32'h0);
    chk("arst_addr", addr, 32'h0);
    chk("arst_valid", {31'h0, valid}, 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_pc4", pc4, 32'h0);
    step();
    reset_n = 1; rvalid = 1; rdata = 32'hBAD1_BAD1;
    step();
    rvalid = 0;
    chk("post_rst_req", {31'h0, req}, 32'h1);
    chk("post_rst_addr", addr, 32'h0);
    chk("post_rst_valid", {31'h0, valid}, 32'h0);
    gnt = 1;
    step();
    gnt = 0; rvalid = 1; rdata = 32'h1111_1111; expect_word(32'h1111_1111, 32'h4);
    step();
    rvalid = 0;

    // Wrap-around reset PC on the second instance
    b_rst_n = 1;
    step();
    chk("b_first_addr", b_addr, 32'hFFFF_FFFC);
    chk("b_req", {31'h0, b_req}, 32'h1);
    b_gnt = 1;
    step();
    b_gnt = 0; b_rvalid = 1; b_rdata = 32'h2008_FFFF;
    step();
    b_rvalid = 0;
    chk("b_valid", {31'h0, b_valid}, 32'h1);
    chk("b_pc4_wrap", b_pc4, 32'h0);
    chk("b_next_addr", b_addr, 32'h0);

    step(); step();
    chk("sb_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
